// File: rtl/seg_debug_monitor.sv
// seg_debug_monitor
// Selects one of NUM_CH probe words, converts it to active-low hex 7-segment
// bytes and shifts the frame MSB-first into the board's segment shift-register
// chain, followed by a latch pulse. Frames start on an update request or on a
// periodic refresh tick. One further request can be queued while a frame runs.
module seg_debug_monitor #(
  parameter int NUM_CH      = 4,
  parameter int DIGITS      = 8,
  parameter int DIV         = 2,
  parameter int REFRESH_CYC = 2**20,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [NUM_CH*4*DIGITS-1:0] ch_data,
  input  logic [SEL_W-1:0]           sel,
  input  logic [DIGITS-1:0]          dp,
  input  logic                       blank,
  input  logic                       hold,
  input  logic                       update,
  output logic                       busy,
  output logic                       seg_clk,
  output logic                       seg_do,
  output logic                       seg_pen,
  output logic                       seg_clr
);

  localparam int CH_W    = 4 * DIGITS;
  localparam int FRAME_W = 8 * DIGITS;
  localparam int PH_W    = $clog2(2 * DIV);
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int RC_W    = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

  // Phase counter values: a bit period is 2*DIV cycles (low half, high half);
  // the latch pulse reuses the same counter for DIV cycles.
  localparam logic [PH_W-1:0]  PH_HALF    = PH_W'(DIV);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(2 * DIV - 1);
  localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);
  localparam logic [RC_W-1:0]  RC_LAST    = RC_W'(REFRESH_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic                 pending_q, pending_d;
  logic [RC_W-1:0]      rcnt_q, rcnt_d;
  logic                 busy_q, busy_d;
  logic                 seg_clk_q, seg_clk_d;
  logic                 seg_do_q, seg_do_d;
  logic                 seg_pen_q, seg_pen_d;
  logic                 seg_clr_q;

  logic                 tick;
  logic                 trig;
  logic                 sel_valid;
  logic [CH_W-1:0]      ch_word;
  logic [FRAME_W-1:0]   frame_enc;

  // Hex nibble to {g,f,e,d,c,b,a}, active-low (0 = segment lit).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Refresh tick fires on the terminal count unless auto-refresh is held off.
  assign tick      = (rcnt_q == RC_LAST) && !hold;
  assign trig      = update || tick;
  assign sel_valid = (int'(sel) < NUM_CH);

  // Channel multiplexer; an out-of-range select leaves the word at zero and
  // is forced blank below.
  always_comb begin
    ch_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(sel) == k) begin
        ch_word = ch_data[k*CH_W +: CH_W];
      end
    end
  end

  // Per-digit segment byte {dp_n, g..a}; digit 0 sits in the lowest byte so
  // the leftmost digit leaves the shift register first.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign frame_enc[gi*8 +: 8] = (blank || !sel_valid) ? 8'hFF
                                : {~dp[gi], hex_to_seg(ch_word[gi*4 +: 4])};
  end

  // Free-running refresh counter, wraps at REFRESH_CYC-1.
  assign rcnt_d = (rcnt_q == RC_LAST) ? '0 : rcnt_q + RC_W'(1);

  // Frame sequencer next-state logic and registered-output precomputation.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    pending_d = pending_q;

    unique case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // Snapshot of all display inputs happens here and only here.
        state_d = ST_SHIFT;
        phase_d = '0;
        bit_d   = '0;
        shift_d = frame_enc;
        if (trig) begin
          pending_d = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (trig) begin
          pending_d = 1'b1;
        end
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          if (bit_q == BIT_LAST) begin
            state_d = ST_LATCH;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      ST_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          phase_d = '0;
          // A trigger on the final latch cycle chains straight into a new
          // frame, just like a request queued earlier.
          if (pending_q || trig) begin
            state_d   = ST_LOAD;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
          if (trig) begin
            pending_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they come straight from
    // flops and stay glitch-free on the board wiring.
    busy_d    = (state_d != ST_IDLE);
    seg_clk_d = (state_d == ST_SHIFT) && (phase_d >= PH_HALF);
    seg_do_d  = (state_d == ST_SHIFT) && shift_d[FRAME_W-1];
    seg_pen_d = (state_d == ST_LATCH);
  end

  // State and output registers; reset aborts any frame and drops the queue.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      pending_q <= 1'b0;
      rcnt_q    <= '0;
      busy_q    <= 1'b0;
      seg_clk_q <= 1'b0;
      seg_do_q  <= 1'b0;
      seg_pen_q <= 1'b0;
      seg_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      pending_q <= pending_d;
      rcnt_q    <= rcnt_d;
      busy_q    <= busy_d;
      seg_clk_q <= seg_clk_d;
      seg_do_q  <= seg_do_d;
      seg_pen_q <= seg_pen_d;
      seg_clr_q <= 1'b1;
    end
  end

  assign busy    = busy_q;
  assign seg_clk = seg_clk_q;
  assign seg_do  = seg_do_q;
  assign seg_pen = seg_pen_q;
  assign seg_clr = seg_clr_q;

endmodule

// File: tb/tb_seg_debug_monitor.sv
// Testbench for seg_debug_monitor: random and directed frames checked against
// a digit-table reference model; one line per captured frame.
module tb_seg_debug_monitor;

  localparam int NUM_CH      = 4;
  localparam int DIGITS      = 8;
  localparam int DIV         = 2;
  localparam int REFRESH_CYC = 1000;
  localparam int SEL_W       = 2;
  localparam int FRAME_LEN   = 1 + 16 * DIGITS * DIV + DIV;
  localparam int PEN_START   = 1 + 16 * DIGITS * DIV;

  logic                 CLK = 1'b0;
  logic                 Reset = 1'b1;
  logic [NUM_CH*32-1:0] ch_data = '0;
  logic [SEL_W-1:0]     sel = '0;
  logic [DIGITS-1:0]    dp = '0;
  logic                 blank = 1'b0;
  logic                 hold = 1'b1;
  logic                 update = 1'b0;
  logic                 busy, seg_clk, seg_do, seg_pen, seg_clr;

  int checks = 0;
  int errors = 0;

  logic [7:0] hex_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 CLK = ~CLK;

  seg_debug_monitor #(
    .NUM_CH(NUM_CH), .DIGITS(DIGITS), .DIV(DIV), .REFRESH_CYC(REFRESH_CYC)
  ) dut (
    .CLK(CLK), .Reset(Reset), .ch_data(ch_data), .sel(sel), .dp(dp),
    .blank(blank), .hold(hold), .update(update), .busy(busy),
    .seg_clk(seg_clk), .seg_do(seg_do), .seg_pen(seg_pen), .seg_clr(seg_clr)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: the displayed bit stream, leftmost digit first, bit7 first.
  function automatic logic [63:0] model_frame(input logic [NUM_CH*32-1:0] data, input int s,
                                              input logic [7:0] d, input logic b);
    logic [63:0] f;
    logic [31:0] w;
    logic [7:0]  sb;
    if (b || s >= NUM_CH) return {64{1'b1}};
    w = data[s*32 +: 32];
    for (int i = 0; i < DIGITS; i++) begin
      sb = hex_lut[w[i*4 +: 4]];
      if (d[i]) sb[7] = 1'b0;
      f[i*8 +: 8] = sb;
    end
    return f;
  endfunction

  task automatic randomize_inputs();
    for (int k = 0; k < NUM_CH; k++) ch_data[k*32 +: 32] = $urandom();
    sel   = SEL_W'($urandom_range(NUM_CH - 1, 0));
    dp    = 8'($urandom());
    blank = ($urandom_range(3, 0) == 0);
  endtask

  task automatic pulse_update();
    update = 1'b1;
    @(negedge CLK);
    update = 1'b0;
  endtask

  // Called at the negedge of a LOAD cycle; observes the chain pins until the
  // cycle after the latch pulse and returns where it stands.
  task automatic capture_frame(input bit scramble, output logic [63:0] bits, output int nbits,
                               output int len, output int busy_cnt, output int pen_cnt,
                               output int pen_start, output int tim_err, output bit done);
    logic prev_clk, prev_do;
    int   low_run, high_run;
    bit   pen_seen;
    bits = '0; nbits = 0; len = 0; busy_cnt = 0; pen_cnt = 0; pen_start = -1;
    tim_err = 0; done = 1'b0;
    prev_clk = 1'b0; prev_do = 1'b0; low_run = 0; high_run = 0; pen_seen = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (pen_seen && !seg_pen) begin
        done = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      if (seg_pen === 1'b1) begin
        if (!pen_seen) pen_start = c;
        pen_seen = 1'b1;
        pen_cnt++;
      end
      if (seg_clk === 1'b1) begin
        if (!prev_clk) begin
          bits = {bits[62:0], seg_do};
          nbits++;
          if (low_run != DIV) tim_err++;
          low_run = 0;
        end
        high_run++;
        if (seg_do !== prev_do) tim_err++;
      end else begin
        if (prev_clk) begin
          if (high_run != DIV) tim_err++;
          high_run = 0;
        end
        if (c > 0) low_run++;
      end
      prev_clk = seg_clk;
      prev_do  = seg_do;
      len++;
      if (scramble && c == 10) randomize_inputs();
      @(negedge CLK);
    end
  endtask

  task automatic count_rises(input int cycles, output int rises);
    logic prev;
    prev  = busy;
    rises = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      if (busy && !prev) rises++;
      prev = busy;
    end
  endtask

  task automatic test_reset();
    logic [63:0] bits; int nb, ln, bc, pc, ps, te, rises; bit dn;
    Reset = 1'b1; hold = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({busy, seg_clk, seg_do, seg_pen, seg_clr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 00000", {busy, seg_clk, seg_do, seg_pen, seg_clr});
    end
    Reset = 1'b0;
    @(negedge CLK);
    checks++;
    if (seg_clr !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: seg_clr=%b busy=%b, expected 1 0", seg_clr, busy);
    end
    // Reset held 3 cycles mid-frame with a request already queued.
    ch_data[31:0] = 32'h0123_4567; sel = 0; dp = 0; blank = 0;
    pulse_update();
    repeat (30) @(negedge CLK);
    pulse_update();
    repeat (5) @(negedge CLK);
    Reset = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({busy, seg_clk, seg_do, seg_pen, seg_clr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_midframe_outputs: got %b, expected 00000", {busy, seg_clk, seg_do, seg_pen, seg_clr});
    end
    Reset = 1'b0;
    @(negedge CLK);
    checks++;
    if (seg_clr !== 1'b1) begin
      errors++;
      $display("FAIL reset_midframe_clr: got %b, expected 1", seg_clr);
    end
    count_rises(600, rises);
    checks++;
    if (rises !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending_dropped: frames=%0d busy=%b, expected 0 0", rises, busy);
    end
    $display("test_reset: done, frames after reset=%0d", rises);
  endtask

  task automatic test_basic();
    logic [63:0] bits, exp; int nb, ln, bc, pc, ps, te; bit dn;
    for (int t = 0; t < 8; t++) begin
      if (t == 0) begin
        ch_data[31:0] = 32'h0123_4567; sel = 0; dp = 0; blank = 0;
        exp = 64'hC0F9_A4B0_9992_82F8;
      end else begin
        randomize_inputs();
        exp = model_frame(ch_data, int'(sel), dp, blank);
      end
      pulse_update();
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_busy_start[%0d]: got %b, expected 1", t, busy);
      end
      capture_frame(t != 0, bits, nb, ln, bc, pc, ps, te, dn);
      $display("frame basic[%0d]: bits=%h expected=%h len=%0d pen=%0d", t, bits, exp, ln, pc);
      checks++;
      if (!dn || bits !== exp || nb != 64) begin
        errors++;
        $display("FAIL basic_bits[%0d]: got %h (%0d bits, done=%0d), expected %h (64 bits)", t, bits, nb, dn, exp);
      end
      checks++;
      if (ln != FRAME_LEN || bc != FRAME_LEN) begin
        errors++;
        $display("FAIL basic_length[%0d]: len=%0d busy=%0d, expected %0d", t, ln, bc, FRAME_LEN);
      end
      checks++;
      if (pc != DIV || ps != PEN_START) begin
        errors++;
        $display("FAIL basic_latch[%0d]: pen cycles=%0d start=%0d, expected %0d at %0d", t, pc, ps, DIV, PEN_START);
      end
      checks++;
      if (te != 0) begin
        errors++;
        $display("FAIL basic_timing[%0d]: %0d timing violations, expected 0", t, te);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy_end[%0d]: got %b, expected 0", t, busy);
      end
      repeat ($urandom_range(5, 0)) @(negedge CLK);
    end
  endtask

  task automatic test_blank();
    logic [63:0] bits, exp; int nb, ln, bc, pc, ps, te; bit dn;
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: begin ch_data[31:0] = 32'h0123_4567; sel = 0; dp = 8'hFF; blank = 1; exp = {64{1'b1}}; end
        1: begin ch_data[31:0] = 32'h0123_4567; sel = 0; dp = 8'h01; blank = 0; exp = 64'hC0F9_A4B0_9992_8278; end
        2: begin ch_data[31:0] = 32'hFFFF_FFFF; sel = 0; dp = 8'h80; blank = 0; exp = 64'h0E8E_8E8E_8E8E_8E8E; end
        default: begin
          randomize_inputs(); blank = 1'b0;
          exp = model_frame(ch_data, int'(sel), dp, blank);
        end
      endcase
      pulse_update();
      capture_frame(1'b0, bits, nb, ln, bc, pc, ps, te, dn);
      $display("frame blank_dp[%0d]: bits=%h expected=%h", t, bits, exp);
      checks++;
      if (!dn || bits !== exp) begin
        errors++;
        $display("FAIL blank_dp[%0d]: got %h, expected %h", t, bits, exp);
      end
    end
    blank = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] bits, exp; int nb, ln, bc, pc, ps, te, rises; bit dn;
    ch_data[31:0] = 32'h1234_5678; sel = 0; dp = 0; blank = 0;
    pulse_update();
    fork
      capture_frame(1'b0, bits, nb, ln, bc, pc, ps, te, dn);
      begin
        repeat (40) @(negedge CLK);
        pulse_update();
        ch_data[31:0] = 32'hFFFF_FFFF;
        repeat (40) @(negedge CLK);
        pulse_update();
      end
    join
    $display("frame b2b_first: bits=%h", bits);
    checks++;
    if (!dn || bits !== 64'hF9A4_B099_9282_F880) begin
      errors++;
      $display("FAIL b2b_first: got %h, expected f9a4b0999282f880", bits);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_chained: busy=%b, expected 1", busy);
    end
    capture_frame(1'b0, bits, nb, ln, bc, pc, ps, te, dn);
    $display("frame b2b_second: bits=%h len=%0d", bits, ln);
    checks++;
    if (!dn || bits !== {8{8'h8E}} || ln != FRAME_LEN) begin
      errors++;
      $display("FAIL b2b_second: got %h len %0d, expected 8e8e8e8e8e8e8e8e len %0d", bits, ln, FRAME_LEN);
    end
    count_rises(300, rises);
    checks++;
    if (rises != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_extra_frames: got %0d more frames, expected 0", rises);
    end
    // Request landing exactly on the last latch cycle.
    ch_data[31:0] = 32'h89AB_CDEF; dp = 8'h0F;
    exp = model_frame(ch_data, 0, dp, 1'b0);
    pulse_update();
    fork
      capture_frame(1'b0, bits, nb, ln, bc, pc, ps, te, dn);
      begin
        repeat (FRAME_LEN - 1) @(negedge CLK);
        pulse_update();
      end
    join
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL latch_edge_chained: busy=%b, expected 1", busy);
    end
    capture_frame(1'b0, bits, nb, ln, bc, pc, ps, te, dn);
    $display("frame latch_edge: bits=%h expected=%h", bits, exp);
    checks++;
    if (!dn || bits !== exp || busy !== 1'b0) begin
      errors++;
      $display("FAIL latch_edge_frame: got %h busy %b, expected %h busy 0", bits, busy, exp);
    end
  endtask

  task automatic test_refresh();
    logic [63:0] bits, exp; int nb, ln, bc, pc, ps, te, rises, first, second; bit dn;
    logic prev;
    hold = 1'b0; Reset = 1'b1;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    first = -1; second = -1; prev = 1'b0;
    for (int c = 1; c <= 2100; c++) begin
      @(negedge CLK);
      if (busy && !prev) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      prev = busy;
    end
    $display("refresh: frame starts at %0d and %0d", first, second);
    checks++;
    if (first != REFRESH_CYC || second != 2 * REFRESH_CYC) begin
      errors++;
      $display("FAIL refresh_period: starts %0d,%0d expected %0d,%0d", first, second, REFRESH_CYC, 2 * REFRESH_CYC);
    end
    hold = 1'b1;
    count_rises(2500, rises);
    checks++;
    if (rises != 0) begin
      errors++;
      $display("FAIL refresh_hold: got %0d frames, expected 0", rises);
    end
    randomize_inputs();
    exp = model_frame(ch_data, int'(sel), dp, blank);
    pulse_update();
    capture_frame(1'b0, bits, nb, ln, bc, pc, ps, te, dn);
    $display("frame hold_update: bits=%h expected=%h", bits, exp);
    checks++;
    if (!dn || bits !== exp) begin
      errors++;
      $display("FAIL hold_update: got %h, expected %h", bits, exp);
    end
    blank = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [63:0] bits, exp; int nb, ln, bc, pc, ps, te, rises; bit dn;
    ch_data[31:0] = 32'hDEAD_BEEF; sel = 0; dp = 0; blank = 0;
    pulse_update();
    repeat (1 + 20 * 2 * DIV) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    checks++;
    if ({busy, seg_clk, seg_do, seg_pen, seg_clr} !== 5'b0) begin
      errors++;
      $display("FAIL bit20_reset_outputs: got %b, expected 00000", {busy, seg_clk, seg_do, seg_pen, seg_clr});
    end
    Reset = 1'b0;
    @(negedge CLK);
    checks++;
    if (seg_clr !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bit20_release: seg_clr=%b busy=%b, expected 1 0", seg_clr, busy);
    end
    count_rises(500, rises);
    checks++;
    if (rises != 0) begin
      errors++;
      $display("FAIL bit20_no_frame: got %0d frames, expected 0", rises);
    end
    randomize_inputs();
    exp = model_frame(ch_data, int'(sel), dp, blank);
    pulse_update();
    capture_frame(1'b0, bits, nb, ln, bc, pc, ps, te, dn);
    $display("frame after_bit20_reset: bits=%h expected=%h", bits, exp);
    checks++;
    if (!dn || bits !== exp || ln != FRAME_LEN) begin
      errors++;
      $display("FAIL bit20_next_frame: got %h len %0d, expected %h len %0d", bits, ln, exp, FRAME_LEN);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blank();
    test_back_to_back();
    test_refresh();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
